spi_servo_master: RTL and testbench

SPI mode-0 master that shifts a servo command word out to the servo driver board. It captures the reply word at the same time. It sits directly downstream of the 100 MHz -> 66.67 kHz clock divider and consumes its square-wave output `sclk_ref` as a timing reference. Every edge of `sclk_ref`, rising or falling, is one half-period "tick" of SPI SCLK. All logic runs on the 100 MHz `clk`; `sclk_ref` is produced in the same domain, so it needs no synchronizer.

---
 rtl/spi_servo_master.sv | 165 ++++++++++++++++
 tb/tb_spi_servo_master.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_servo_master.sv
// SPI mode-0 master whose SCLK half-periods are paced by edges of an external reference clock.
// One command word goes out on MOSI while the reply word is captured from MISO.
module spi_servo_master #(
  parameter int DATA_W         = 16,
  parameter int CS_SETUP_TICKS = 1,
  parameter int CS_HOLD_TICKS  = 1,
  parameter int GAP_TICKS      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_ref,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_cs_n
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  // The tick counter holds ticks already seen, so the terminal tick is the one arriving at N-1.
  localparam logic [7:0]       SETUP_LAST = 8'(CS_SETUP_TICKS - 1);
  localparam logic [7:0]       HOLD_LAST  = 8'(CS_HOLD_TICKS - 1);
  localparam logic [7:0]       GAP_LAST   = 8'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_W);

  logic [2:0]        state_q, state_d;
  logic              sclk_ref_q;
  logic [7:0]        tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              tick;

  assign tick     = sclk_ref ^ sclk_ref_q;
  assign tx_ready = (state_q == IDLE) && !rst;
  assign busy     = (state_q != IDLE);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          state_d    = SETUP;
          cs_n_d     = 1'b0;
          mosi_d     = tx_data[DATA_W-1];
          tx_sr_d    = tx_data;
          tick_cnt_d = 8'd0;
        end
      end
      SETUP: begin
        if (tick) begin
          if (tick_cnt_q == SETUP_LAST) begin
            // The last setup tick doubles as the first SCLK rising edge.
            state_d   = SHIFT;
            sclk_d    = 1'b1;
            rx_sr_d   = {rx_sr_q[DATA_W-2:0], spi_miso};
            bit_cnt_d = CNT_W'(1);
          end else begin
            tick_cnt_d = tick_cnt_q + 8'd1;
          end
        end
      end
      SHIFT: begin
        if (tick) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bit_cnt_q == LAST_BIT) begin
              state_d    = HOLD;
              tick_cnt_d = 8'd0;
              mosi_d     = 1'b0;
            end else begin
              tx_sr_d = tx_sr_q << 1;
              mosi_d  = tx_sr_q[DATA_W-2];
            end
          end else begin
            sclk_d    = 1'b1;
            rx_sr_d   = {rx_sr_q[DATA_W-2:0], spi_miso};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (tick) begin
          if (tick_cnt_q == HOLD_LAST) begin
            cs_n_d     = 1'b1;
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
            tick_cnt_d = 8'd0;
            state_d    = (GAP_TICKS == 0) ? IDLE : GAP;
          end else begin
            tick_cnt_d = tick_cnt_q + 8'd1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (tick_cnt_q == GAP_LAST) begin
            state_d = IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sclk_ref_q <= 1'b0;
      tick_cnt_q <= 8'd0;
      bit_cnt_q  <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      sclk_ref_q <= sclk_ref;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
    end
  end
endmodule

// File: tb/tb_spi_servo_master.sv
// Bench for spi_servo_master: a default instance (u0) and an 8-bit, 3-setup, no-gap instance (u1).
// A tick-indexed frame model predicts every output each cycle; directed frames add literal checks.
module tb_spi_servo_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk_ref = 1'b0;
  logic        freeze = 1'b0;
  logic [15:0] txd0 = '0;
  logic [7:0]  txd1 = '0;
  logic [1:0]  tx_valid = '0;
  logic [1:0]  miso = '0;
  wire  [1:0]  o_ready, o_rxv, o_busy, o_sclk, o_mosi, o_cs;
  wire  [15:0] rx0;
  wire  [7:0]  rx1;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_servo_master #(.DATA_W(16), .CS_SETUP_TICKS(1), .CS_HOLD_TICKS(1), .GAP_TICKS(2)) dut0 (
    .clk(clk), .rst(rst), .sclk_ref(sclk_ref), .tx_data(txd0), .tx_valid(tx_valid[0]),
    .tx_ready(o_ready[0]), .rx_data(rx0), .rx_valid(o_rxv[0]), .busy(o_busy[0]),
    .spi_sclk(o_sclk[0]), .spi_mosi(o_mosi[0]), .spi_miso(miso[0]), .spi_cs_n(o_cs[0]));

  spi_servo_master #(.DATA_W(8), .CS_SETUP_TICKS(3), .CS_HOLD_TICKS(1), .GAP_TICKS(0)) dut1 (
    .clk(clk), .rst(rst), .sclk_ref(sclk_ref), .tx_data(txd1), .tx_valid(tx_valid[1]),
    .tx_ready(o_ready[1]), .rx_data(rx1), .rx_valid(o_rxv[1]), .busy(o_busy[1]),
    .spi_sclk(o_sclk[1]), .spi_mosi(o_mosi[1]), .spi_miso(miso[1]), .spi_cs_n(o_cs[1]));

  // Reference square wave: one edge every 4 clk unless frozen.
  initial forever begin
    repeat (4) @(negedge clk);
    if (!freeze) sclk_ref = ~sclk_ref;
  end

  function automatic int p_n(input int u); return (u == 0) ? 16 : 8; endfunction
  function automatic int p_s(input int u); return (u == 0) ? 1 : 3;  endfunction
  function automatic int p_h(input int u); return 1;                  endfunction
  function automatic int p_g(input int u); return (u == 0) ? 2 : 0;  endfunction
  function automatic int hold_end(input int u); return p_s(u) + 2 * p_n(u) - 1 + p_h(u); endfunction
  function automatic int frame_len(input int u); return hold_end(u) + p_g(u); endfunction

  // Frame model: everything follows from k = reference edges seen since acceptance.
  bit          in_fr [2];
  int          k [2];
  logic [31:0] m_word [2];
  logic [31:0] rxw [2];
  logic [31:0] e_rxd [2];
  bit          e_rxv [2];
  logic [31:0] pat [2];
  bit          tick_now = 1'b0;
  logic        sref_prev = 1'b0;

  function automatic bit is_high(input int u, input int kk);
    return (kk >= p_s(u)) && (kk <= p_s(u) + 2 * p_n(u) - 2) && (((kk - p_s(u)) % 2) == 0);
  endfunction
  function automatic bit e_cs(input int u);
    return !(in_fr[u] && (k[u] < hold_end(u)));
  endfunction
  function automatic bit e_sclk(input int u);
    return in_fr[u] && is_high(u, k[u]);
  endfunction
  function automatic bit e_mosi(input int u);
    int b;
    logic [31:0] w;
    if (!in_fr[u]) return 1'b0;
    b = (k[u] < p_s(u) + 1) ? 0 : (k[u] - p_s(u) + 1) / 2;
    w = m_word[u];
    return (b < p_n(u)) ? w[p_n(u) - 1 - b] : 1'b0;
  endfunction
  function automatic int rises_done(input int u);
    if (!in_fr[u] || k[u] < p_s(u)) return 0;
    return ((k[u] - p_s(u)) / 2 + 1 > p_n(u)) ? p_n(u) : (k[u] - p_s(u)) / 2 + 1;
  endfunction

  initial begin
    for (int u = 0; u < 2; u++) begin
      in_fr[u] = 0; k[u] = 0; m_word[u] = '0; rxw[u] = '0; e_rxd[u] = '0; e_rxv[u] = 0; pat[u] = '0;
    end
  end

  initial forever begin
    @(posedge clk);
    tick_now  = (sclk_ref !== sref_prev);
    sref_prev = rst ? 1'b0 : sclk_ref;
    for (int u = 0; u < 2; u++) begin
      e_rxv[u] = 1'b0;
      if (rst) begin
        in_fr[u] = 0; k[u] = 0; e_rxd[u] = '0;
      end else if (!in_fr[u]) begin
        if (tx_valid[u]) begin
          in_fr[u] = 1; k[u] = 0; rxw[u] = '0;
          m_word[u] = (u == 0) ? {16'b0, txd0} : {24'b0, txd1};
        end
      end else if (tick_now) begin
        k[u]++;
        if (is_high(u, k[u])) rxw[u] = {rxw[u][30:0], miso[u]};
        if (k[u] == hold_end(u)) begin e_rxv[u] = 1'b1; e_rxd[u] = rxw[u]; end
        if (k[u] == frame_len(u)) in_fr[u] = 0;
      end
    end
  end

  // Slave side: present the next reply bit ahead of each rising edge.
  initial forever begin
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      int rc;
      logic [31:0] pw;
      rc = rises_done(u);
      pw = pat[u];
      miso[u] = (in_fr[u] && rc < p_n(u)) ? pw[p_n(u) - 1 - rc] : 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d cs_n", u),     32'(o_cs[u]),    32'(e_cs(u)));
      chk($sformatf("u%0d sclk", u),     32'(o_sclk[u]),  32'(e_sclk(u)));
      chk($sformatf("u%0d mosi", u),     32'(o_mosi[u]),  32'(e_mosi(u)));
      chk($sformatf("u%0d busy", u),     32'(o_busy[u]),  32'(in_fr[u]));
      chk($sformatf("u%0d tx_ready", u), 32'(o_ready[u]), 32'(!in_fr[u] && !rst));
      chk($sformatf("u%0d rx_valid", u), 32'(o_rxv[u]),   32'(e_rxv[u]));
      chk($sformatf("u%0d rx_data", u),  (u == 0) ? {16'b0, rx0} : {24'b0, rx1}, e_rxd[u]);
    end
  end

  // Observation counters feeding the literal checks.
  logic        p_sclk [2], p_cs [2], p_busy [2], p_mosi [2];
  int          rises [2], cs_lo [2], gap_t [2], pre_hi [2], rxv_cnt [2];
  logic [31:0] mcap [2];
  logic        rdy_at_cs_rise [2];

  task automatic clr(input int u);
    rises[u] = 0; cs_lo[u] = 0; gap_t[u] = 0; pre_hi[u] = 0; rxv_cnt[u] = 0;
    mcap[u] = '0; rdy_at_cs_rise[u] = 1'b0;
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      p_sclk[u] = 0; p_cs[u] = 1; p_busy[u] = 0; p_mosi[u] = 0;
      clr(u);
    end
    forever begin
      @(posedge clk);
      #2;
      for (int u = 0; u < 2; u++) begin
        if (tick_now && !rst) begin
          if (!p_cs[u]) cs_lo[u]++;
          if (p_cs[u] && p_busy[u]) gap_t[u]++;
          if (!p_cs[u] && rises[u] == 0 && p_mosi[u]) pre_hi[u]++;
        end
        if (!p_sclk[u] && o_sclk[u]) begin
          rises[u]++;
          mcap[u] = {mcap[u][30:0], o_mosi[u]};
        end
        if (!p_cs[u] && o_cs[u]) rdy_at_cs_rise[u] = o_ready[u];
        rxv_cnt[u] += int'(o_rxv[u]);
        p_sclk[u] = o_sclk[u]; p_cs[u] = o_cs[u]; p_busy[u] = o_busy[u]; p_mosi[u] = o_mosi[u];
      end
    end
  end

  task automatic wait_ready(input int u, input string nm);
    for (int i = 0; i < 3000; i++) begin
      if (o_ready[u]) break;
      @(negedge clk);
    end
    chk({nm, " ready within bound"}, 32'(o_ready[u]), 32'd1);
  endtask

  task automatic send(input int u, input logic [15:0] d);
    @(negedge clk);
    if (u == 0) txd0 = d; else txd1 = d[7:0];
    tx_valid[u] = 1'b1;
    wait_ready(u, $sformatf("u%0d send", u));
    @(negedge clk);
    tx_valid[u] = 1'b0;
  endtask

  task automatic wait_idle(input int u);
    for (int i = 0; i < 3000; i++) begin
      if (!o_busy[u]) break;
      @(negedge clk);
    end
    chk($sformatf("u%0d frame ends within bound", u), 32'(o_busy[u]), 32'd0);
  endtask

  task automatic wait_rises(input int u, input int n);
    for (int i = 0; i < 3000; i++) begin
      if (rises[u] >= n) break;
      @(negedge clk);
    end
    chk($sformatf("u%0d reached rising edge %0d", u, n), 32'(rises[u]), 32'(n));
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset cs_n", 32'(o_cs[0]), 32'd1);
    chk("reset sclk", 32'(o_sclk[0]), 32'd0);
    chk("reset ready low in rst", 32'(o_ready[0]), 32'd0);
    chk("reset rx_data", {16'b0, rx0}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready after release", 32'(o_ready[0]), 32'd1);

    // Single frame
    pat[0] = 32'h3C5A;
    clr(0);
    send(0, 16'hA5C3);
    wait_idle(0);
    chk("t1 rising edges", 32'(rises[0]), 32'd16);
    chk("t1 mosi word", mcap[0], 32'hA5C3);
    chk("t1 rx_data", {16'b0, rx0}, 32'h3C5A);
    chk("t1 model rx", e_rxd[0], 32'h3C5A);
    chk("t1 rx_valid pulses", 32'(rxv_cnt[0]), 32'd1);
    chk("t1 cs low ticks", 32'(cs_lo[0]), 32'd33);
    chk("t1 gap ticks", 32'(gap_t[0]), 32'd2);

    // tx_valid pulse while busy is ignored
    pat[0] = 32'h1234;
    clr(0);
    send(0, 16'h0F0F);
    repeat (40) @(negedge clk);
    chk("t3 busy during pulse", 32'(o_busy[0]), 32'd1);
    txd0 = 16'hFFFF;
    tx_valid[0] = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    wait_idle(0);
    repeat (20) @(negedge clk);
    chk("t3 no second frame", 32'(o_busy[0]), 32'd0);
    chk("t3 rx_valid pulses", 32'(rxv_cnt[0]), 32'd1);
    chk("t3 mosi word", mcap[0], 32'h0F0F);
    chk("t3 rx_data", {16'b0, rx0}, 32'h1234);

    // Back-to-back with tx_valid held through the busy period
    pat[0] = 32'h0;
    clr(0);
    send(0, 16'h0001);
    txd0 = 16'hFFFF;
    tx_valid[0] = 1'b1;
    wait_ready(0, "t2 second word");
    chk("t2 first mosi word", mcap[0], 32'h0001);
    chk("t2 gap ticks", 32'(gap_t[0]), 32'd2);
    clr(0);
    @(negedge clk);
    tx_valid[0] = 1'b0;
    wait_idle(0);
    chk("t2 second mosi word", mcap[0], 32'hFFFF);
    chk("t2 second rises", 32'(rises[0]), 32'd16);
    chk("t2 rx_data", {16'b0, rx0}, 32'h0);

    // Reset mid-frame
    pat[0] = 32'hFFFF;
    clr(0);
    send(0, 16'h5555);
    wait_rises(0, 5);
    rst = 1'b1;
    @(negedge clk);
    chk("t4 cs_n", 32'(o_cs[0]), 32'd1);
    chk("t4 sclk", 32'(o_sclk[0]), 32'd0);
    chk("t4 mosi", 32'(o_mosi[0]), 32'd0);
    chk("t4 ready in rst", 32'(o_ready[0]), 32'd0);
    repeat (2) @(negedge clk);
    chk("t4 no rx_valid", 32'(rxv_cnt[0]), 32'd0);
    chk("t4 rx_data kept", {16'b0, rx0}, 32'h0);
    rst = 1'b0;
    pat[0] = 32'hC3A5;
    clr(0);
    send(0, 16'h1357);
    wait_idle(0);
    chk("t4 after mosi word", mcap[0], 32'h1357);
    chk("t4 after rx_data", {16'b0, rx0}, 32'hC3A5);
    chk("t4 after rx_valid", 32'(rxv_cnt[0]), 32'd1);

    // 8-bit instance, long setup, no gap
    pat[1] = 32'h5A;
    clr(1);
    send(1, 16'h0081);
    wait_idle(1);
    chk("t5 mosi high before first rise", 32'(pre_hi[1]), 32'd3);
    chk("t5 rising edges", 32'(rises[1]), 32'd8);
    chk("t5 mosi word", mcap[1], 32'h81);
    chk("t5 rx_data", {24'b0, rx1}, 32'h5A);
    chk("t5 ready as cs rises", 32'(rdy_at_cs_rise[1]), 32'd1);
    chk("t5 cs low ticks", 32'(cs_lo[1]), 32'd19);

    // Stalled reference mid-shift
    pat[0] = 32'h6B2D;
    clr(0);
    send(0, 16'hD4B1);
    wait_rises(0, 6);
    freeze = 1'b1;
    repeat (1000) @(negedge clk);
    chk("t6 still busy", 32'(o_busy[0]), 32'd1);
    chk("t6 cs held low", 32'(o_cs[0]), 32'd0);
    chk("t6 no edges while frozen", 32'(rises[0]), 32'd6);
    freeze = 1'b0;
    wait_idle(0);
    chk("t6 mosi word", mcap[0], 32'hD4B1);
    chk("t6 rx_data", {16'b0, rx0}, 32'h6B2D);
    chk("t6 rising edges", 32'(rises[0]), 32'd16);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
